// File: rtl/sha256_padder.sv
// rtl/sha256_padder.sv - SHA-256 message padder: 32-bit word stream in, padded 512-bit blocks out
//
// Appends the 0x80 marker byte, zero fill and the 64-bit message bit length
// to a byte-granular message, emitting 16 words per block.
//
// Parameter:
//   CNT_W      width of the message byte counter
// Ports:
//   aclk       clock, rising edge
//   aresetn    synchronous active-low reset
//   in_data    message word, byte k in bits [8k+7:8k]
//   in_bytes   valid bytes in in_data (1..4, 0 only as empty tail with in_last)
//   in_last    final word of the message
//   in_valid   upstream word valid
//   in_ready   upstream word ready
//   out_data   padded output word
//   out_valid  output word valid
//   out_ready  downstream ready
//   out_blast  last word (index 15) of each block
//   out_mlast  last word of the final block
//   busy       message in flight
//
// Build option: define SHA256_PADDER_BSWAP_EN to emit each output word
// byte-reversed (big-endian, byte 0 in [31:24]).

module sha256_padder #(
    parameter int CNT_W = 32
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic [31:0] in_data,
    input  logic [2:0]  in_bytes,
    input  logic        in_last,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_blast,
    output logic        out_mlast,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_DATA,
        S_PAD,
        S_LEN_HI,
        S_LEN_LO
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       idx;
    logic [3:0]       idx_nxt;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             need_80;
    logic             need_80_nxt;
    logic             busy_nxt;

    logic             load_en;
    logic             accept;
    logic             emit;
    logic             emit_blast;
    logic             emit_mlast;
    logic [31:0]      emit_word;
    logic [31:0]      data_word;
    logic [31:0]      fmt_word;
    logic [2:0]       n_bytes;
    logic [63:0]      len_bits;

    function automatic logic [31:0] bswap32(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Output register accepts a new word when empty or draining this cycle.
    assign load_en  = !out_valid || out_ready;
    assign in_ready = aresetn && (state == S_DATA) && load_en;
    assign accept   = in_valid && in_ready;

    // Out-of-range byte counts are treated as a full word.
    assign n_bytes  = (in_bytes > 3'd4) ? 3'd4 : in_bytes;
    assign len_bits = 64'(byte_cnt) << 3;

    // Keep the valid bytes, put the 0x80 marker right after them, clear the rest.
    // A full word (n_bytes == 4) passes through untouched.
    always_comb begin
        data_word = '0;
        for (int k = 0; k < 4; k++) begin
            if (k < int'(n_bytes)) begin
                data_word[8*k +: 8] = in_data[8*k +: 8];
            end else if (k == int'(n_bytes)) begin
                data_word[8*k +: 8] = 8'h80;
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        cnt_nxt     = byte_cnt;
        need_80_nxt = need_80;
        emit        = 1'b0;
        emit_word   = '0;
        emit_blast  = 1'b0;
        emit_mlast  = 1'b0;

        case (state)
            S_DATA: begin
                // An empty non-final word is consumed without producing output.
                if (accept && (n_bytes != 3'd0 || in_last)) begin
                    emit       = 1'b1;
                    emit_word  = data_word;
                    emit_blast = (idx == 4'd15);
                    idx_nxt    = idx + 4'd1;
                    cnt_nxt    = byte_cnt + CNT_W'(n_bytes);
                    if (in_last) begin
                        if (n_bytes == 3'd4) begin
                            // No room for the marker: it goes out as its own word.
                            state_nxt   = S_PAD;
                            need_80_nxt = 1'b1;
                        end else if (idx == 4'd13) begin
                            state_nxt = S_LEN_HI;
                        end else begin
                            state_nxt = S_PAD;
                        end
                    end
                end
            end

            S_PAD: begin
                // Zero fill stops after index 13. When the marker landed at 14
                // or 15 the index wraps through a whole extra block first.
                if (load_en) begin
                    emit        = 1'b1;
                    emit_word   = need_80 ? 32'h0000_0080 : 32'h0000_0000;
                    emit_blast  = (idx == 4'd15);
                    idx_nxt     = idx + 4'd1;
                    need_80_nxt = 1'b0;
                    if (idx == 4'd13) begin
                        state_nxt = S_LEN_HI;
                    end
                end
            end

            S_LEN_HI: begin
                if (load_en) begin
                    emit      = 1'b1;
                    emit_word = bswap32(len_bits[63:32]);
                    idx_nxt   = idx + 4'd1;
                    state_nxt = S_LEN_LO;
                end
            end

            S_LEN_LO: begin
                if (load_en) begin
                    emit       = 1'b1;
                    emit_word  = bswap32(len_bits[31:0]);
                    emit_blast = 1'b1;
                    emit_mlast = 1'b1;
                    idx_nxt    = 4'd0;
                    cnt_nxt    = '0;
                    state_nxt  = S_DATA;
                end
            end

            default: begin
                state_nxt = S_DATA;
            end
        endcase

        // A new message may start in the cycle the previous one's last word leaves.
        busy_nxt = busy;
        if (out_valid && out_ready && out_mlast) begin
            busy_nxt = 1'b0;
        end
        if (accept) begin
            busy_nxt = 1'b1;
        end
    end

`ifdef SHA256_PADDER_BSWAP_EN
    assign fmt_word = bswap32(emit_word);
`else
    assign fmt_word = emit_word;
`endif

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state     <= S_DATA;
            idx       <= 4'd0;
            byte_cnt  <= '0;
            need_80   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= 32'h0;
            out_blast <= 1'b0;
            out_mlast <= 1'b0;
        end else begin
            state    <= state_nxt;
            idx      <= idx_nxt;
            byte_cnt <= cnt_nxt;
            need_80  <= need_80_nxt;
            busy     <= busy_nxt;
            if (load_en) begin
                out_valid <= emit;
                out_blast <= emit_blast;
                out_mlast <= emit_mlast;
                if (emit) begin
                    out_data <= fmt_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_padder.sv
// tb/tb_sha256_padder.sv - directed self-checking bench for sha256_padder
module tb_sha256_padder;

    logic        aclk      = 1'b0;
    logic        aresetn   = 1'b0;
    logic [31:0] in_data   = 32'h0;
    logic [2:0]  in_bytes  = 3'd0;
    logic        in_last   = 1'b0;
    logic        in_valid  = 1'b0;
    logic        in_ready;
    logic [31:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_blast;
    logic        out_mlast;
    logic        busy;

    int checks = 0;
    int errors = 0;
    bit rdy_rand = 1'b0;
    bit gaps     = 1'b0;

    typedef struct packed {
        logic [31:0] d;
        logic        b;
        logic        m;
    } rec_t;

    rec_t        got[$];
    logic [31:0] exp_w[64];
    int          exp_n;
    logic [31:0] msg_w[16];

    always #5 aclk = ~aclk;

    sha256_padder #(.CNT_W(32)) dut (
        .aclk      (aclk),
        .aresetn   (aresetn),
        .in_data   (in_data),
        .in_bytes  (in_bytes),
        .in_last   (in_last),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_blast (out_blast),
        .out_mlast (out_mlast),
        .busy      (busy)
    );

    // Output monitor: a word seen valid&ready at the falling edge transfers
    // on the following rising edge.
    always @(negedge aclk) begin
        if (aresetn && out_valid && out_ready) begin
            got.push_back(rec_t'({out_data, out_blast, out_mlast}));
        end
    end

    initial begin
        forever begin
            @(posedge aclk);
            #1;
            out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic l);
        int cyc = 0;
        bit done = 1'b0;
        int g = gaps ? int'($urandom_range(0, 2)) : 0;
        repeat (g) begin
            @(posedge aclk);
            #1;
        end
        in_data  = d;
        in_bytes = nb;
        in_last  = l;
        in_valid = 1'b1;
        while (!done && cyc < 1000) begin
            @(negedge aclk);
            if (in_ready) done = 1'b1;
            @(posedge aclk);
            #1;
            cyc++;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("in_accept", 32'(done), 32'd1);
    endtask

    task automatic send_msg(input int n, input logic [2:0] last_bytes);
        for (int i = 0; i < n; i++) begin
            send_word(msg_w[i], (i == n - 1) ? last_bytes : 3'd4, i == n - 1);
        end
    endtask

    task automatic set_exp(input int n);
        exp_n = n;
        for (int i = 0; i < 64; i++) exp_w[i] = 32'h0;
    endtask

    task automatic expect_msg(input string name);
        int cyc = 0;
        while (got.size() < exp_n && cyc < 3000) begin
            @(posedge aclk);
            #1;
            cyc++;
        end
        repeat (4) begin
            @(posedge aclk);
            #1;
        end
        check($sformatf("%s_count", name), 32'(got.size()), 32'(exp_n));
        for (int i = 0; i < exp_n && i < got.size(); i++) begin
            check($sformatf("%s_w%0d", name, i), got[i].d, exp_w[i]);
            check($sformatf("%s_blast%0d", name, i), 32'(got[i].b), 32'(i % 16 == 15));
            check($sformatf("%s_mlast%0d", name, i), 32'(got[i].m), 32'(i == exp_n - 1));
        end
        check($sformatf("%s_busy_idle", name), 32'(busy), 32'd0);
        got.delete();
    endtask

    initial begin
        for (int i = 0; i < 16; i++) msg_w[i] = 32'h6434_3962 + 32'h0101_0101 * 32'(i);

        // Reset values
        aresetn = 1'b0;
        repeat (3) @(posedge aclk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_blast", 32'(out_blast), 32'd0);
        check("rst_out_mlast", 32'(out_mlast), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", out_data, 32'h0);
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        check("in_ready_idle", 32'(in_ready), 32'd1);

        // 64-byte message: marker gets its own word, extra block
        set_exp(32);
        for (int i = 0; i < 16; i++) exp_w[i] = msg_w[i];
        exp_w[16] = 32'h0000_0080;
        exp_w[31] = 32'h0002_0000;
        send_msg(16, 3'd4);
        check("m64_busy", 32'(busy), 32'd1);
        expect_msg("m64");

        // "abc"
        set_exp(16);
        exp_w[0]  = 32'h8063_6261;
        exp_w[15] = 32'h1800_0000;
        send_word(32'h0063_6261, 3'd3, 1'b1);
        expect_msg("abc");

        // Empty message
        set_exp(16);
        exp_w[0] = 32'h0000_0080;
        send_word(32'h0, 3'd0, 1'b0 | 1'b1);
        expect_msg("empty");

        // Empty non-final word is ignored, then "abc"
        set_exp(16);
        exp_w[0]  = 32'h8063_6261;
        exp_w[15] = 32'h1800_0000;
        send_word(32'hDEAD_BEEF, 3'd0, 1'b0);
        send_word(32'h0063_6261, 3'd3, 1'b1);
        expect_msg("skip_abc");

        // 56 bytes: marker at index 14 forces an extra block
        set_exp(32);
        for (int i = 0; i < 14; i++) exp_w[i] = msg_w[i];
        exp_w[14] = 32'h0000_0080;
        exp_w[31] = 32'hC001_0000;
        send_msg(14, 3'd4);
        expect_msg("m56");

        // 60 bytes: marker at index 15
        set_exp(32);
        for (int i = 0; i < 15; i++) exp_w[i] = msg_w[i];
        exp_w[15] = 32'h0000_0080;
        exp_w[31] = 32'hE001_0000;
        send_msg(15, 3'd4);
        expect_msg("m60");

        // 64-byte message under random backpressure and input gaps
        rdy_rand = 1'b1;
        gaps     = 1'b1;
        set_exp(32);
        for (int i = 0; i < 16; i++) exp_w[i] = msg_w[i];
        exp_w[16] = 32'h0000_0080;
        exp_w[31] = 32'h0002_0000;
        send_msg(16, 3'd4);
        expect_msg("m64_bp");

        // Reset after word 5, then "abc" must come out exactly
        for (int i = 0; i < 6; i++) send_word(msg_w[i], 3'd4, 1'b0);
        check("mid_busy", 32'(busy), 32'd1);
        aresetn = 1'b0;
        repeat (2) @(posedge aclk);
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        got.delete();
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        set_exp(16);
        exp_w[0]  = 32'h8063_6261;
        exp_w[15] = 32'h1800_0000;
        send_word(32'h0063_6261, 3'd3, 1'b1);
        expect_msg("abc_after_rst");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
